// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP divider retire path.
package fpu_pkg;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam int unsigned FLAG_NV = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

  localparam int unsigned RETIRE_RD_W = 5;

  typedef struct packed {
    logic [63:0]            data;
    logic [RETIRE_RD_W-1:0] rd;
    fflags_t                flags;
  } retire_entry_t;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccFull  = 2'd2
  } occ_e;

  // Single-precision values live in the low half with all-ones above.
  function automatic logic [63:0] nanbox(input logic [63:0] res, input logic is_double);
    return is_double ? res : {NANBOX_HI, res[31:0]};
  endfunction

endpackage

// File: rtl/fpu_retire_fifo.sv
// Two-entry circular skid buffer with occupancy count and synchronous flush.
module fpu_retire_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned W     = 73,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam logic [1:0] FullCount = 2'(DEPTH);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  occ_e         count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = OccEmpty;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = occ_e'(count_q + 2'd1);
        2'b01:   count_d = occ_e'(count_q - 2'd1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= OccEmpty;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == OccEmpty);
  assign full  = (count_q == FullCount);

endmodule

// File: rtl/fpu_result_retire.sv
// Retire stage after the FP divider: NaN-boxing, skid buffering, sticky fflags.
module fpu_result_retire
  import fpu_pkg::*;
#(
  parameter int unsigned RD_W  = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_result,
  input  logic            in_is_double,
  input  logic [RD_W-1:0] in_rd,
  input  logic [3:0]      in_flags,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [63:0]     wb_data,
  input  logic            flush,
  input  logic            fflags_clr,
  output logic [3:0]      fflags
);

  typedef struct packed {
    logic [63:0]     data;
    logic [RD_W-1:0] rd;
    fflags_t         flags;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  entry_t  push_entry, head;
  logic    push, pop, empty, full;
  fflags_t fflags_q, fflags_d;

  assign push_entry = '{data: nanbox(in_result, in_is_double), rd: in_rd, flags: in_flags};

  // in_ready comes straight from the occupancy register, never from wb_ready.
  assign in_ready = !full;
  assign wb_valid = !empty;
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;

  fpu_retire_fifo #(
    .W     (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_entry),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  assign wb_rd   = head.rd;
  assign wb_data = head.data;

  // A retiring op's flags survive a same-cycle clear; a flushed pop contributes nothing.
  always_comb begin
    fflags_d = fflags_clr ? '0 : fflags_q;
    if (pop && !flush) fflags_d = fflags_d | head.flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fflags_q <= '0;
    else        fflags_q <= fflags_d;
  end

  assign fflags = fflags_q;

endmodule
